// File: rtl/systolic_edge_feeder_if.sv
// Handshake and edge bus for systolic_edge_feeder.
// FEEDER_STALL_CNT_EN adds the stall_cnt observation signal.
interface systolic_edge_feeder_if #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16,
  parameter int KW      = 8
);
  logic                      start;
  logic [KW-1:0]             k_len;
  logic                      in_valid;
  logic                      in_ready;
  logic [ROWS*WIDTH_A-1:0]   in_a;
  logic [COLS*WIDTH_B-1:0]   in_b;
  logic [ROWS*WIDTH_A-1:0]   out_west;
  logic [COLS*WIDTH_B-1:0]   out_north;
  logic                      busy;
  logic                      tile_done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]               stall_cnt;
`endif

  modport master (
    output start, k_len, in_valid, in_a, in_b,
    input  in_ready, out_west, out_north, busy, tile_done
`ifdef FEEDER_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  start, k_len, in_valid, in_a, in_b,
    output in_ready, out_west, out_north, busy, tile_done
`ifdef FEEDER_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/systolic_edge_feeder.sv
// West/north edge feeder for a ROWS x COLS systolic array: diagonal skew, zero drain, tile_done pulse.
// Optional FEEDER_STALL_CNT_EN adds a saturating count of idle STREAM cycles.
module systolic_edge_feeder #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int WIDTH_A     = 16,
  parameter int WIDTH_B     = 16,
  parameter int KW          = 8,
  parameter int EXTRA_DRAIN = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  systolic_edge_feeder_if.slave  bus
);

  localparam int DRAIN_LEN = ROWS + COLS - 1 + EXTRA_DRAIN;
  localparam int DW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] k_cnt_q, k_cnt_d;
  logic [DW-1:0] d_cnt_q, d_cnt_d;
  logic          in_ready;
  logic          busy;
  logic          tile_done;
  logic          accept;

  assign accept = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_len_q <= '0;
      k_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      k_cnt_q <= k_cnt_d;
      d_cnt_q <= d_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_len_d   = k_len_q;
    k_cnt_d   = k_cnt_q;
    d_cnt_d   = d_cnt_q;
    in_ready  = 1'b0;
    busy      = 1'b1;
    tile_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          k_len_d = bus.k_len;
          k_cnt_d = '0;
          d_cnt_d = '0;
          state_d = (bus.k_len != '0) ? S_STREAM : S_DRAIN;
        end
      end
      S_STREAM: begin
        in_ready = 1'b1;
        if (accept) begin
          k_cnt_d = k_cnt_q + KW'(1);
          if (k_cnt_q == k_len_q - KW'(1)) begin
            d_cnt_d = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        d_cnt_d = d_cnt_q + DW'(1);
        if (d_cnt_q == DW'(DRAIN_LEN - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        tile_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.tile_done = tile_done;

  // Lane i is i+1 stages deep; a non-accept cycle shifts a zero bubble in on both edges alike.
  for (genvar i = 0; i < ROWS; i++) begin : g_west
    localparam int DEPTH = i + 1;
    logic [DEPTH*WIDTH_A-1:0] sr_q;
    logic [WIDTH_A-1:0]       inj;

    assign inj = accept ? bus.in_a[i*WIDTH_A +: WIDTH_A] : '0;

    if (DEPTH == 1) begin : g_d1
      always_ff @(posedge clk) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= inj;
      end
    end else begin : g_dn
      always_ff @(posedge clk) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= {sr_q[(DEPTH-1)*WIDTH_A-1:0], inj};
      end
    end

    assign bus.out_west[i*WIDTH_A +: WIDTH_A] = sr_q[DEPTH*WIDTH_A-1 -: WIDTH_A];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_north
    localparam int DEPTH = j + 1;
    logic [DEPTH*WIDTH_B-1:0] sr_q;
    logic [WIDTH_B-1:0]       inj;

    assign inj = accept ? bus.in_b[j*WIDTH_B +: WIDTH_B] : '0;

    if (DEPTH == 1) begin : g_d1
      always_ff @(posedge clk) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= inj;
      end
    end else begin : g_dn
      always_ff @(posedge clk) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= {sr_q[(DEPTH-1)*WIDTH_B-1:0], inj};
      end
    end

    assign bus.out_north[j*WIDTH_B +: WIDTH_B] = sr_q[DEPTH*WIDTH_B-1 -: WIDTH_B];
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && bus.start) begin
      stall_d = '0;
    end else if (state_q == S_STREAM && !bus.in_valid && stall_q != '1) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Directed bench for systolic_edge_feeder (2x2, 16-bit lanes) with a 2x2 accumulating PE model.
// Build with FEEDER_STALL_CNT_EN to also exercise the stall counter.
module tb_systolic_edge_feeder;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int WA   = 16;
  localparam int WB   = 16;
  localparam int KW   = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  systolic_edge_feeder_if #(.ROWS(ROWS), .COLS(COLS), .WIDTH_A(WA), .WIDTH_B(WB), .KW(KW)) bus ();

  systolic_edge_feeder #(
    .ROWS(ROWS), .COLS(COLS), .WIDTH_A(WA), .WIDTH_B(WB), .KW(KW), .EXTRA_DRAIN(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Accumulating PE array fed by the feeder edges: a hops east, b hops south.
  logic signed [15:0] pa [2][2];
  logic signed [15:0] pb [2][2];
  logic signed [31:0] acc [2][2];
  logic               pe_clr = 1'b0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        pa[i][j] <= (j == 0) ? $signed(bus.out_west[i*16 +: 16]) : pa[i][j-1];
        pb[i][j] <= (i == 0) ? $signed(bus.out_north[j*16 +: 16]) : pb[i-1][j];
        acc[i][j] <= pe_clr ? 32'sd0 : acc[i][j] + pa[i][j] * pb[i][j];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        st;
    logic [7:0]  kl;
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic        rdy;
    logic        busy;
    logic        done;
    logic [31:0] w;
    logic [31:0] n;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [7:0] kl, input logic v,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic rdy, input logic busy, input logic done,
                              input logic [31:0] w, input logic [31:0] n);
    vec_t r;
    r.st = st; r.kl = kl; r.v = v; r.a = a; r.b = b;
    r.rdy = rdy; r.busy = busy; r.done = done; r.w = w; r.n = n;
    return r;
  endfunction

  // Injected-vector history for the hand sequences: index 0 is the most recent edge.
  logic [31:0] ha0 = '0, ha1 = '0, hb0 = '0, hb1 = '0;

  task automatic step(input logic st, input logic [7:0] kl, input logic v,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic e_rdy, input logic e_busy, input logic e_done);
    bus.start = st; bus.k_len = kl; bus.in_valid = v; bus.in_a = a; bus.in_b = b;
    @(negedge clk);
    chk("seq_in_ready", 32'(bus.in_ready), 32'(e_rdy));
    chk("seq_busy", 32'(bus.busy), 32'(e_busy));
    chk("seq_tile_done", 32'(bus.tile_done), 32'(e_done));
    chk("seq_out_west", bus.out_west, {ha1[31:16], ha0[15:0]});
    chk("seq_out_north", bus.out_north, {hb1[31:16], hb0[15:0]});
    @(posedge clk);
    if (!rst_n) begin
      ha0 = '0; ha1 = '0; hb0 = '0; hb1 = '0;
    end else begin
      ha1 = ha0; hb1 = hb0;
      ha0 = (e_rdy && v) ? a : 32'h0;
      hb0 = (e_rdy && v) ? b : 32'h0;
    end
    #1;
  endtask

  localparam int NV = 19;
  vec_t tbl [NV];

  int signed   ma [2][3];
  int signed   mb [3][2];
  int signed   ref_c;
  logic [31:0] sa [3];
  logic [31:0] sb [3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0,                         0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0,                         0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 0,                         0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 32'h0200_0100, 32'h0400_0300, 1, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 1, 0, 32'h0000_0100, 32'h0000_0300);
    tbl[5]  = mk(0, 0, 0, 0, 0,                         0, 1, 0, 32'h0200_0000, 32'h0400_0000);
    tbl[6]  = mk(0, 0, 0, 0, 0,                         0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0,                         0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0,                         0, 1, 0, 0, 0);
    tbl[9]  = mk(1, 1, 0, 0, 0,                         0, 1, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0,                         0, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0,                         0, 0, 0, 0, 0);
    for (int i = 12; i <= 16; i++)
      tbl[i] = mk(0, 0, 1, 32'h1111_2222, 32'h3333_4444, 0, 1, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0,                         0, 1, 1, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0,                         0, 0, 0, 0, 0);

    ma = '{'{1, -2, 3}, '{4, 5, -6}};
    mb = '{'{7, 8}, '{-9, 10}, '{11, -12}};
    for (int k = 0; k < 3; k++) begin
      sa[k] = {16'(ma[1][k]), 16'(ma[0][k])};
      sb[k] = {16'(mb[k][1]), 16'(mb[k][0])};
    end

    rst_n = 1'b0;
    bus.start = 0; bus.k_len = 0; bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // k_len=1 single slice, start ignored in DONE, then k_len=0 drain-only tile
    for (int i = 0; i < NV; i++) begin
      bus.start = tbl[i].st; bus.k_len = tbl[i].kl; bus.in_valid = tbl[i].v;
      bus.in_a = tbl[i].a; bus.in_b = tbl[i].b;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_tile_done", i), 32'(bus.tile_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_out_west", i), bus.out_west, tbl[i].w);
      chk($sformatf("tbl%0d_out_north", i), bus.out_north, tbl[i].n);
      @(posedge clk);
      #1;
    end

    // k_len=3 with a 2-cycle bubble between slices 1 and 2, checked against integer matmul
    pe_clr = 1'b1;
    step(1, 3, 0, 0, 0, 0, 0, 0);
    pe_clr = 1'b0;
    step(0, 0, 1, sa[0], sb[0], 1, 1, 0);
    step(1, 3, 1, sa[1], sb[1], 1, 1, 0);
    step(0, 0, 0, 32'h7777_7777, 32'h5555_5555, 1, 1, 0);
    step(0, 0, 0, 32'h7777_7777, 32'h5555_5555, 1, 1, 0);
    step(0, 0, 1, sa[2], sb[2], 1, 1, 0);
    repeat (5) step(0, 0, 1, 32'hABCD_1234, 32'h4321_DCBA, 0, 1, 0);
    step(1, 2, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        ref_c = 0;
        for (int k = 0; k < 3; k++) ref_c += ma[i][k] * mb[k][j];
        chk($sformatf("pe_acc_%0d%0d", i, j), acc[i][j], ref_c);
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // reset during STREAM after 1 of 3 slices aborts silently; next tile runs normally
    step(1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h0A0A_0B0B, 32'h0C0C_0D0D, 1, 1, 0);
    rst_n = 1'b0;
    step(0, 0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h0003_0001, 32'h0007_0005, 1, 1, 0);
    step(0, 0, 1, 32'h0004_0002, 32'h0008_0006, 1, 1, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);

`ifdef FEEDER_STALL_CNT_EN
    // 4 idle STREAM cycles counted, then cleared by the next accepted start
    step(1, 2, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0);
    step(0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0);
    step(0, 0, 1, 32'h0010_0020, 32'h0030_0040, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 1, 32'h0050_0060, 32'h0070_0080, 1, 1, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("stall_cnt_drain", 32'(bus.stall_cnt), 32'd4);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("stall_cnt_after_done", 32'(bus.stall_cnt), 32'd4);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("stall_cnt_cleared", 32'(bus.stall_cnt), 32'd0);
    step(0, 0, 1, 32'h0001_0001, 32'h0001_0001, 1, 1, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
